bram_tdp_pipe: RTL



---
 rtl/bram_tdp_pipe_if.sv | 22 ++
 rtl/bram_tdp_pipe.sv | 115 +++++++++++
 2 files changed

// File: rtl/bram_tdp_pipe_if.sv
// bram_tdp_pipe_if: request/response bundle for both ports of bram_tdp_pipe
interface bram_tdp_pipe_if #(
    parameter int DW = 36,
    parameter int AW = 10,
    parameter int BW = 9
);
    localparam int NB = DW / BW;
    logic          enA, enB;
    logic [NB-1:0] weA, weB;
    logic [AW-1:0] addrA, addrB;
    logic [DW-1:0] dinA, dinB, doutA, doutB;
    logic          validA, validB, ready, collision;
    logic [15:0]   coll_cnt;
    modport master (
        output enA, enB, weA, weB, addrA, addrB, dinA, dinB,
        input  doutA, doutB, validA, validB, ready, collision, coll_cnt
    );
    modport slave (
        input  enA, enB, weA, weB, addrA, addrB, dinA, dinB,
        output doutA, doutB, validA, validB, ready, collision, coll_cnt
    );
endinterface

// File: rtl/bram_tdp_pipe.sv
// bram_tdp_pipe: true dual-port BRAM with byte enables, pipelined reads and collision counting
// Define BRAM_TDP_INIT_CLEAR_EN to zero the whole array after reset before requests are accepted.
module bram_tdp_pipe #(
    parameter int DW      = 36,
    parameter int AW      = 10,
    parameter int BW      = 9,
    parameter int RD_MODE = 0,
    parameter int OUT_REG = 1
) (
    input logic            clk,
    input logic            rstn,
    bram_tdp_pipe_if.slave bus
);
    localparam int NB = DW / BW;
    logic [DW-1:0]      mem [2**AW];
    logic               ready, clrWe, same, conflict, coll;
    logic [AW-1:0]      clrAddr;
    logic [15:0]        collCnt;
    logic [1:0]         acc, v1, v2;
    logic [1:0][AW-1:0] addr;
    logic [1:0][DW-1:0] din, old, newW, rdData, d1, d2;
    logic [1:0][NB-1:0] we, wrL;

    assign addr     = {bus.addrB, bus.addrA};
    assign din      = {bus.dinB, bus.dinA};
    assign we       = {bus.weB, bus.weA};
    assign acc      = {bus.enB, bus.enA} & {2{ready}};
    assign same     = bus.addrA == bus.addrB;
    assign conflict = &acc && same && (|bus.weA || |bus.weB);
    // A owns any lane both ports write at the same address
    assign wrL[0]   = {NB{acc[0]}} & bus.weA;
    assign wrL[1]   = {NB{acc[1]}} & bus.weB & ~({NB{same}} & wrL[0]);

    for (genvar p = 0; p < 2; p++) begin : gPort
        assign old[p] = mem[addr[p]];
        for (genvar i = 0; i < NB; i++) begin : gLane
            assign newW[p][i*BW +: BW] = wrL[p][i] ? din[p][i*BW +: BW] :
                (same && wrL[1-p][i]) ? din[1-p][i*BW +: BW] : old[p][i*BW +: BW];
        end
        // a port that is only reading always sees the old word
        assign rdData[p] = (RD_MODE != 0 && we[p] != '0) ? newW[p] : old[p];
    end

    always_ff @(posedge clk) begin
        if (clrWe) mem[clrAddr] <= '0;
        if (|wrL[0]) mem[addr[0]] <= newW[0];
        if (|wrL[1]) mem[addr[1]] <= newW[1];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1      <= '0;
            d1      <= '0;
            coll    <= 1'b0;
            collCnt <= '0;
        end else begin
            v1   <= acc;
            coll <= conflict;
            if (acc[0]) d1[0] <= rdData[0];
            if (acc[1]) d1[1] <= rdData[1];
            if (conflict && collCnt != 16'hFFFF) collCnt <= collCnt + 16'd1;
        end
    end

    if (OUT_REG != 0) begin : gOutReg
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                v2 <= '0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                if (v1[0]) d2[0] <= d1[0];
                if (v1[1]) d2[1] <= d1[1];
            end
        end
    end else begin : gNoReg
        assign v2 = v1;
        assign d2 = d1;
    end

    assign bus.validA    = v2[0];
    assign bus.validB    = v2[1];
    assign bus.doutA     = d2[0];
    assign bus.doutB     = d2[1];
    assign bus.ready     = ready;
    assign bus.collision = coll;
    assign bus.coll_cnt  = collCnt;

`ifdef BRAM_TDP_INIT_CLEAR_EN
    typedef enum logic {INIT, RUN} state_t;
    state_t state, nextState;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= INIT;
            clrAddr <= '0;
        end else begin
            state <= nextState;
            if (state == INIT) clrAddr <= clrAddr + AW'(1);
        end
    end

    always_comb begin
        nextState = state;
        if (state == INIT && clrAddr == '1) nextState = RUN;
    end

    assign ready = state == RUN;
    assign clrWe = state == INIT;
`else
    assign ready   = 1'b1;
    assign clrWe   = 1'b0;
    assign clrAddr = '0;
`endif
endmodule
